if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC select, IF/ID pipeline register.

---
 rtl/cpu_defs.sv | 33 +++
 rtl/ifid_reg.sv | 30 +++
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset PC, nop encoding, opcodes and the IF/ID payload.
package cpu_defs;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t PC_RESET_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_INSTR        = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    typedef enum logic {
        REDIR_IDLE    = 1'b0,
        REDIR_PENDING = 1'b1
    } redir_state_e;

    typedef struct packed {
        word_t pc;
        word_t pc4;
        word_t instr;
        logic  valid;
    } ifid_t;

    // Word-align a redirect target; low bits are never meaningful for fetch.
    function automatic word_t alignTarget(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats squash, otherwise load.
module ifid_reg
    import cpu_defs::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  stall,
    input  logic  squash,
    input  word_t pc,
    input  word_t instr,
    output ifid_t q,
    output logic  loadBubble_c,
    output logic  loadValid_c
);

    assign loadBubble_c = flush | (~stall & squash);
    assign loadValid_c  = ~flush & ~stall & ~squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (loadBubble_c) begin
            q <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (loadValid_c) begin
            q <= '{pc: pc, pc4: pc + word_t'(4), instr: instr, valid: 1'b1};
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select with a pending-redirect latch,
// IF/ID register and fetch/bubble counters.
module if_stage
    import cpu_defs::*;
#(
    parameter word_t PC_RESET           = PC_RESET_DEFAULT,
    parameter bit    SQUASH_ON_REDIRECT = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IFID_Stall,
    input  logic        IFID_Flush,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump_Taken,
    input  logic [31:0] Jump_Target,
    output logic [31:0] Imem_Addr,
    input  logic [31:0] Imem_Instr,
    output logic [31:0] PC_IFID,
    output logic [31:0] PC4_IFID,
    output logic [31:0] Instr_IFID,
    output logic        Valid_IFID,
    output logic        Redirect_Pending,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Bubble_Count
);

    redir_state_e state, stateNext;
    word_t        pc, pcNext;
    word_t        pendTarget, pendTargetNext;
    word_t        liveTarget;
    word_t        fetchCount, bubbleCount;
    logic         liveRedirect, redirectApplied;
    logic         loadBubble_c, loadValid_c;
    ifid_t        ifid;

    // Branch wins over jump when ID reports both.
    assign liveRedirect    = Branch_Taken | Jump_Taken;
    assign liveTarget      = Branch_Taken ? alignTarget(Branch_Target) : alignTarget(Jump_Target);
    assign redirectApplied = PCWre & (liveRedirect | (state == REDIR_PENDING));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= REDIR_IDLE;
            pc         <= PC_RESET;
            pendTarget <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            pendTarget <= pendTargetNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        pendTargetNext = pendTarget;
        if (PCWre) begin
            stateNext = REDIR_IDLE;
            if (liveRedirect) begin
                pcNext = liveTarget;
            end else if (state == REDIR_PENDING) begin
                pcNext = pendTarget;
            end else begin
                pcNext = pc + word_t'(4);
            end
        end else if (liveRedirect) begin
            // Frozen PC: remember the newest redirect until the PC is released.
            stateNext      = REDIR_PENDING;
            pendTargetNext = liveTarget;
        end
    end

    ifid_reg u_ifid_reg (
        .clk          (CLK),
        .rst_n        (Reset),
        .flush        (IFID_Flush),
        .stall        (IFID_Stall),
        .squash       (redirectApplied & SQUASH_ON_REDIRECT),
        .pc           (pc),
        .instr        (Imem_Instr),
        .q            (ifid),
        .loadBubble_c (loadBubble_c),
        .loadValid_c  (loadValid_c)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fetchCount  <= '0;
            bubbleCount <= '0;
        end else begin
            if (loadValid_c)  fetchCount  <= fetchCount + word_t'(1);
            if (loadBubble_c) bubbleCount <= bubbleCount + word_t'(1);
        end
    end

    assign Imem_Addr        = pc;
    assign PC_IFID          = ifid.pc;
    assign PC4_IFID         = ifid.pc4;
    assign Instr_IFID       = ifid.instr;
    assign Valid_IFID       = ifid.valid;
    assign Redirect_Pending = (state == REDIR_PENDING);
    assign Fetch_Count      = fetchCount;
    assign Bubble_Count     = bubbleCount;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/hazard scenarios then random traffic against a reference model.
module tb_if_stage;
    import cpu_defs::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre, IFID_Stall, IFID_Flush, Branch_Taken, Jump_Taken;
    logic [31:0] Branch_Target, Jump_Target, Imem_Addr, Imem_Instr;
    logic [31:0] PC_IFID, PC4_IFID, Instr_IFID, Fetch_Count, Bubble_Count;
    logic        Valid_IFID, Redirect_Pending;

    int unsigned nVec = 0;
    int unsigned nErr = 0;

    // Reference model state
    word_t mPc, mPendTgt, mIfPc, mIfPc4, mIfInstr, mFetch, mBub;
    logic  mPend, mValid;

    always #5 CLK = ~CLK;

    function automatic word_t imemWord(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
    endfunction

    assign Imem_Instr = imemWord(Imem_Addr);

    if_stage dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .PCWre            (PCWre),
        .IFID_Stall       (IFID_Stall),
        .IFID_Flush       (IFID_Flush),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .Jump_Taken       (Jump_Taken),
        .Jump_Target      (Jump_Target),
        .Imem_Addr        (Imem_Addr),
        .Imem_Instr       (Imem_Instr),
        .PC_IFID          (PC_IFID),
        .PC4_IFID         (PC4_IFID),
        .Instr_IFID       (Instr_IFID),
        .Valid_IFID       (Valid_IFID),
        .Redirect_Pending (Redirect_Pending),
        .Fetch_Count      (Fetch_Count),
        .Bubble_Count     (Bubble_Count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mPend = 1'b0; mPendTgt = '0;
        mIfPc = '0; mIfPc4 = '0; mIfInstr = '0; mValid = 1'b0;
        mFetch = '0; mBub = '0;
    endtask

    task automatic checkAll();
        chk("imem_addr", Imem_Addr, mPc);
        chk("pc_ifid", PC_IFID, mIfPc);
        chk("pc4_ifid", PC4_IFID, mIfPc4);
        chk("instr_ifid", Instr_IFID, mIfInstr);
        chk("valid_ifid", 32'(Valid_IFID), 32'(mValid));
        chk("redirect_pending", 32'(Redirect_Pending), 32'(mPend));
        chk("fetch_count", Fetch_Count, mFetch);
        chk("bubble_count", Bubble_Count, mBub);
    endtask

    // Apply one cycle of inputs (called just after a falling edge), advance the model, check.
    task automatic step(input logic pw, input logic st, input logic fl,
                        input logic bt, input word_t btg, input logic jt, input word_t jtg);
        logic  live, applied;
        word_t tgt;
        PCWre = pw; IFID_Stall = st; IFID_Flush = fl;
        Branch_Taken = bt; Branch_Target = btg; Jump_Taken = jt; Jump_Target = jtg;
        live    = bt | jt;
        tgt     = bt ? {btg[31:2], 2'b00} : {jtg[31:2], 2'b00};
        applied = pw && (live || mPend);
        if (fl || (!st && applied)) begin
            mIfPc = '0; mIfPc4 = '0; mIfInstr = '0; mValid = 1'b0; mBub++;
        end else if (!st) begin
            mIfPc = mPc; mIfPc4 = mPc + 32'd4; mIfInstr = imemWord(mPc); mValid = 1'b1; mFetch++;
        end
        if (pw) begin
            mPc   = live ? tgt : (mPend ? mPendTgt : mPc + 32'd4);
            mPend = 1'b0;
        end else if (live) begin
            mPend = 1'b1; mPendTgt = tgt;
        end
        @(posedge CLK);
        @(negedge CLK);
        checkAll();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        Reset = 1'b0; PCWre = 1'b0; IFID_Stall = 1'b0; IFID_Flush = 1'b0;
        Branch_Taken = 1'b0; Jump_Taken = 1'b0; Branch_Target = '0; Jump_Target = '0;
        modelReset();
        repeat (2) @(negedge CLK);
        checkAll();
        Reset = 1'b1;

        // Sequential fetch from the reset vector
        run(1);
        chk("first_instr", Instr_IFID, 32'h2001_0005);
        chk("first_pc_ifid", PC_IFID, 32'h0);
        run(3);
        chk("pc_at_0x10", Imem_Addr, 32'h10);

        // Frozen PC with stalled IF/ID
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("stall_pc_hold", Imem_Addr, 32'h10);
        run(1);
        chk("resume_pc", Imem_Addr, 32'h14);

        // Taken branch squashes the wrong-path fetch
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
        chk("branch_pc", Imem_Addr, 32'h40);
        chk("branch_bubble", 32'(Valid_IFID), 32'h0);

        // Jump latched while the PC is frozen
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h80);
        chk("pending_set", 32'(Redirect_Pending), 32'h1);
        chk("pending_pc_hold", Imem_Addr, 32'h40);
        run(1);
        chk("pending_applied", Imem_Addr, 32'h80);
        chk("pending_cleared", 32'(Redirect_Pending), 32'h0);

        // Branch priority and target alignment
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        chk("branch_over_jump", Imem_Addr, 32'h40);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h43, 1'b0, '0);
        chk("align_target", Imem_Addr, 32'h40);

        // PC wrap at the top of the address space
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
        chk("pc_top", Imem_Addr, 32'hFFFF_FFFC);
        run(1);
        chk("pc_wrap", Imem_Addr, 32'h0);

        // Async reset discards a pending redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h200);
        chk("pending_before_reset", 32'(Redirect_Pending), 32'h1);
        #2 Reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge CLK);
        Reset = 1'b1;
        run(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
                 ($urandom % 6) == 0, $urandom, ($urandom % 6) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
